mult_div_unit: RTL

Iterative 32-bit multiply/divide unit for the MIPS EX-stage MultDiv extension, with architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU with a fixed latency and raises busy so the hazard unit stalls MFHI/MFLO and further mult/div issue. It produces the products and quotients that the program later stores to the test port (e.g. the 8! = 40320 result).

---
 rtl/mult_div_pkg.sv | 30 +++
 rtl/mult_div_unit_datapath.sv | 56 +++++
 rtl/mult_div_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the divide-by-zero quotient.
package mult_div_pkg;

    localparam int MD_DATA_W = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } md_state_e;

    localparam logic [MD_DATA_W-1:0] DIV0_QUOT = {MD_DATA_W{1'b1}};

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_datapath.sv
// One radix-2 iteration per step: shift-add multiply or restoring divide.
// acc holds {upper/remainder, lower/multiplier-or-quotient}.
module md_datapath #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic           is_div,
    input  logic [W-1:0]   load_lo,
    input  logic [W-1:0]   load_opnd,
    output logic [2*W-1:0] acc
);

    logic [2*W-1:0] acc_r;
    logic [W-1:0]   opnd_r;
    logic [2*W-1:0] acc_next_s;
    logic [W:0]     sum_s;
    logic [W:0]     shifted_s;
    logic [W+1:0]   diff_s;

    // Next accumulator value for one iteration of the selected operation
    always_comb begin
        acc_next_s = acc_r;
        sum_s      = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
        shifted_s  = {acc_r[2*W-1:W], acc_r[W-1]};
        diff_s     = {1'b0, shifted_s} - {2'b00, opnd_r};
        if (is_div) begin
            // No borrow means the divisor fits: keep the difference, shift in a 1
            if (!diff_s[W+1]) begin
                acc_next_s = {diff_s[W-1:0], acc_r[W-2:0], 1'b1};
            end else begin
                acc_next_s = {shifted_s[W-1:0], acc_r[W-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {sum_s, acc_r[W-1:1]};
        end
    end

    // Accumulator and operand registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r  <= {(2*W){1'b0}};
            opnd_r <= {W{1'b0}};
        end else if (load) begin
            acc_r  <= {{W{1'b0}}, load_lo};
            opnd_r <= load_opnd;
        end else if (step) begin
            acc_r  <= acc_next_s;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO, busy and done.
// Operands are made positive at issue; the sign is restored in the FIX cycle.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              mthi,
    input  logic              mtlo,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] abs_of(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? -v : v;
    endfunction

    md_state_e           state_r, state_s;
    logic [CNT_W-1:0]    cnt_r;
    md_op_e              op_r;
    logic                neg_q_r, neg_r_r, div0_r;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   hi_r, lo_r;
    logic                busy_r, done_r;
    logic [2*DATA_W-1:0] acc_s, prod_s;
    logic [DATA_W-1:0]   res_hi_s, res_lo_s;
    logic [DATA_W-1:0]   abs_a_s, abs_b_s;
    logic                launch_s, in_signed_s, in_div_s;

    assign in_signed_s = op_is_signed(md_op_e'(op));
    assign in_div_s    = op_is_div(md_op_e'(op));
    assign launch_s    = (state_r == S_IDLE) && start;
    assign abs_a_s     = abs_of(src_a, in_signed_s);
    assign abs_b_s     = abs_of(src_b, in_signed_s);

    md_datapath #(.W(DATA_W)) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (launch_s),
        .step      (state_r == S_CALC),
        .is_div    (op_is_div(op_r)),
        .load_lo   (in_div_s ? abs_a_s : abs_b_s),
        .load_opnd (in_div_s ? abs_b_s : abs_a_s),
        .acc       (acc_s)
    );

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_CALC;
                else       state_s = S_IDLE;
            end
            S_CALC: begin
                if (cnt_r == CNT_LAST) state_s = S_FIX;
                else                   state_s = S_CALC;
            end
            S_FIX:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Sign fix-up and divide-by-zero override of the raw magnitude result
    always_comb begin
        prod_s   = neg_q_r ? -acc_s : acc_s;
        res_hi_s = prod_s[2*DATA_W-1:DATA_W];
        res_lo_s = prod_s[DATA_W-1:0];
        if (op_is_div(op_r)) begin
            if (div0_r) begin
                res_lo_s = DATA_W'(DIV0_QUOT);
                res_hi_s = a_r;
            end else begin
                res_lo_s = neg_q_r ? -acc_s[DATA_W-1:0] : acc_s[DATA_W-1:0];
                res_hi_s = neg_r_r ? -acc_s[2*DATA_W-1:DATA_W] : acc_s[2*DATA_W-1:DATA_W];
            end
        end else begin
            res_hi_s = prod_s[2*DATA_W-1:DATA_W];
            res_lo_s = prod_s[DATA_W-1:0];
        end
    end

    // FSM state, iteration counter and issue-time bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= MD_MULT;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            div0_r  <= 1'b0;
            a_r     <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (launch_s) begin
                cnt_r   <= {CNT_W{1'b0}};
                op_r    <= md_op_e'(op);
                neg_q_r <= in_signed_s & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                neg_r_r <= in_signed_s & src_a[DATA_W-1];
                div0_r  <= (src_b == {DATA_W{1'b0}});
                a_r     <= src_a;
            end else if (state_r == S_CALC) begin
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Architectural HI/LO plus registered busy/done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r   <= {DATA_W{1'b0}};
            lo_r   <= {DATA_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != S_IDLE);
            done_r <= (state_r == S_FIX);
            if (state_r == S_FIX) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end else if (state_r == S_IDLE) begin
                if (mthi) hi_r <= src_a;
                if (mtlo) lo_r <= src_a;
            end
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
